// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the CPU MEM stage and an external loader; grant is combinational, ext read data is registered.
// Optional build macro MEM_ARB_RR_EN: round-robin plain contention (default: CPU wins plain contention).
module mem_port_arbiter #(
  parameter int BURST_MAX  = 8,
  parameter int STARVE_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic        ext_lock,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic [31:0] ext_rdata,
  output logic        ext_rvalid,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} owner_t;

  localparam logic [4:0] BMAX   = BURST_MAX[4:0];
  localparam logic [4:0] SMAX   = STARVE_MAX[4:0];
  localparam logic [4:0] CNT_SAT = 5'd31;

  owner_t     last_owner;
  logic       last_lock;
  logic [4:0] burst_cnt;
  logic [4:0] starve_cnt;
  logic       cpu_gnt;
  logic       burst_cont;
  logic       starved;

  always_comb begin
    cpu_gnt    = 1'b0;
    ext_gnt    = 1'b0;
    burst_cont = (last_owner == OWN_EXT) && last_lock && (burst_cnt < BMAX);
    starved    = (starve_cnt >= SMAX);
    if (rst_n) begin
      if (cpu_req && ext_req) begin
        if (burst_cont || starved) begin
          ext_gnt = 1'b1;
        end else begin
`ifdef MEM_ARB_RR_EN
          if (last_owner == OWN_CPU) ext_gnt = 1'b1;
          else                       cpu_gnt = 1'b1;
`else
          cpu_gnt = 1'b1;
`endif
        end
      end else begin
        cpu_gnt = cpu_req;
        ext_gnt = ext_req;
      end
    end
  end

  // Grants are already forced low in reset, so every output below follows.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (cpu_gnt) begin
      mem_read  = ~cpu_we;
      mem_write = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt) begin
      mem_read  = ~ext_we;
      mem_write = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  assign cpu_stall = rst_n & cpu_req & ~cpu_gnt;
  assign cpu_rdata = (cpu_gnt && !cpu_we) ? mem_rdata : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_CPU;
      last_lock  <= 1'b0;
      burst_cnt  <= 5'd0;
      starve_cnt <= 5'd0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= 32'd0;
    end else begin
      if (cpu_gnt) begin
        last_owner <= OWN_CPU;
        last_lock  <= 1'b0;
      end else if (ext_gnt) begin
        last_owner <= OWN_EXT;
        last_lock  <= ext_lock;
      end

      if (ext_gnt && ext_lock)
        burst_cnt <= (burst_cnt == CNT_SAT) ? CNT_SAT : burst_cnt + 5'd1;
      else
        burst_cnt <= 5'd0;

      if (ext_req && !ext_gnt)
        starve_cnt <= (starve_cnt == CNT_SAT) ? CNT_SAT : starve_cnt + 5'd1;
      else
        starve_cnt <= 5'd0;

      ext_rvalid <= ext_gnt & ~ext_we;
      if (ext_gnt && !ext_we)
        ext_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a cycle-level behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int BURST_MAX  = 8;
  localparam int STARVE_MAX = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, mem_rdata;
  logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, ext_gnt, ext_rvalid, mem_read, mem_write;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: who last owned the port, whether that grant was locked,
  // locked-beat count, denied-cycle count, and the pending ext read return.
  bit          m_last_ext;
  bit          m_lock;
  int          m_burst;
  int          m_starve;
  bit          m_rvalid;
  logic [31:0] m_rdata;

  mem_port_arbiter #(.BURST_MAX(BURST_MAX), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 31) ? 31 : v + 1;
  endfunction

  // Called at a negedge with inputs already driven; checks this cycle, then
  // advances the model across the next posedge and returns at the following negedge.
  task automatic step(output logic got_ext, output logic got_stall);
    bit ec, ee;
    #1;
    if (!rst_n) begin
      m_last_ext = 0; m_lock = 0; m_burst = 0; m_starve = 0; m_rvalid = 0; m_rdata = 32'd0;
    end
    ec = 0; ee = 0;
    if (rst_n) begin
      if (cpu_req && ext_req) begin
        if ((m_last_ext && m_lock && m_burst < BURST_MAX) || m_starve >= STARVE_MAX) ee = 1;
`ifdef MEM_ARB_RR_EN
        else if (!m_last_ext) ee = 1;
        else ec = 1;
`else
        else ec = 1;
`endif
      end else begin
        ec = cpu_req; ee = ext_req;
      end
    end
    check("ext_gnt",    32'(ext_gnt),    32'(ee));
    check("cpu_stall",  32'(cpu_stall),  32'(rst_n & cpu_req & ~ec));
    check("mem_read",   32'(mem_read),   32'((ec & ~cpu_we) | (ee & ~ext_we)));
    check("mem_write",  32'(mem_write),  32'((ec & cpu_we) | (ee & ext_we)));
    check("mem_addr",   mem_addr,  ec ? cpu_addr  : ee ? ext_addr  : 32'd0);
    check("mem_wdata",  mem_wdata, ec ? cpu_wdata : ee ? ext_wdata : 32'd0);
    check("cpu_rdata",  cpu_rdata, (ec && !cpu_we) ? mem_rdata : 32'd0);
    check("ext_rvalid", 32'(ext_rvalid), 32'(m_rvalid));
    check("ext_rdata",  ext_rdata, m_rdata);
    got_ext   = ext_gnt;
    got_stall = cpu_stall;
    @(posedge clk);
    if (rst_n) begin
      if (ec || ee) begin
        m_last_ext = ee;
        m_lock     = ee && ext_lock;
      end
      m_burst  = (ee && ext_lock) ? sat_inc(m_burst) : 0;
      m_starve = (ext_req && !ee) ? sat_inc(m_starve) : 0;
      if (ee && !ext_we) begin
        m_rvalid = 1; m_rdata = mem_rdata;
      end else begin
        m_rvalid = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic randomize_data();
    cpu_we    = 1'($urandom_range(0, 1));
    ext_we    = 1'($urandom_range(0, 1));
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    ext_addr  = $urandom;
    ext_wdata = $urandom;
    mem_rdata = $urandom;
  endtask

  task automatic do_reset();
    logic g, s;
    rst_n = 1'b0;
    randomize_data();
    step(g, s);
    rst_n = 1'b1;
  endtask

  initial begin
    logic g, s;
    int   ext_cnt;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; ext_req = 0; ext_we = 0; ext_lock = 0;
    cpu_addr = 0; cpu_wdata = 0; ext_addr = 0; ext_wdata = 0; mem_rdata = 0;
    @(negedge clk);

    // Reset state with requests active: everything must read 0.
    cpu_req = 1; ext_req = 1; randomize_data();
    step(g, s);
    check("reset_ext_gnt", 32'(g), 32'd0);
    check("reset_stall",   32'(s), 32'd0);
    rst_n = 1'b1;

    // Lone CPU write.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hA5; ext_req = 0;
    #1;
    check("w_mem_write", 32'(mem_write), 32'd1);
    check("w_mem_addr",  mem_addr, 32'h10);
    check("w_mem_wdata", mem_wdata, 32'hA5);
    check("w_stall",     32'(cpu_stall), 32'd0);
    step(g, s);

    // Lone ext read: data returns one cycle later, for one cycle only.
    cpu_req = 0; ext_req = 1; ext_we = 0; ext_lock = 0; ext_addr = 32'h40; mem_rdata = 32'h12345678;
    step(g, s);
    ext_req = 0; mem_rdata = 32'hDEADBEEF;
    #1;
    check("rd_rvalid", 32'(ext_rvalid), 32'd1);
    check("rd_rdata",  ext_rdata, 32'h12345678);
    step(g, s);
    #1;
    check("rd_rvalid_drop", 32'(ext_rvalid), 32'd0);
    check("rd_rdata_hold",  ext_rdata, 32'h12345678);
    step(g, s);

    // Continuous contention, unlocked: starvation guard lets ext in on cycle 17.
    do_reset();
    cpu_req = 1; ext_req = 1; ext_lock = 0;
    ext_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      randomize_data();
      step(g, s);
      if (g) ext_cnt++;
`ifndef MEM_ARB_RR_EN
      if (i == 15 || i == 16 || i == 17) check($sformatf("starve_c%0d", i), 32'(g), 32'(i == 16));
`endif
    end
`ifndef MEM_ARB_RR_EN
    check("starve_ext_total", 32'(ext_cnt), 32'd1);
`endif

    // Locked burst entered via starvation: 8 ext beats, then cpu.
    do_reset();
    cpu_req = 1; ext_req = 1; ext_lock = 1;
    ext_cnt = 0;
    for (int i = 0; i < 26; i++) begin
      randomize_data();
      step(g, s);
      if (g) ext_cnt++;
      check($sformatf("burst_stall_eq_gnt_%0d", i), 32'(s), 32'(g));
    end
`ifndef MEM_ARB_RR_EN
    check("burst_ext_total", 32'(ext_cnt), 32'(BURST_MAX));
`endif

    // Reset during the third burst beat, then contention resolves to cpu.
    do_reset();
    cpu_req = 1; ext_req = 1; ext_lock = 1;
    for (int i = 0; i < 18; i++) begin
      randomize_data();
      step(g, s);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_ext_gnt", 32'(ext_gnt),   32'd0);
    check("midrst_stall",   32'(cpu_stall), 32'd0);
    check("midrst_write",   32'(mem_write | mem_read), 32'd0);
    check("midrst_addr",    mem_addr, 32'd0);
    check("midrst_rdata",   cpu_rdata, 32'd0);
    step(g, s);
    rst_n = 1'b1;
    step(g, s);
    check("postrst_ext_gnt", 32'(g), 32'd0);
    check("postrst_stall",   32'(s), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cpu_req  = ($urandom_range(0, 9) < 6);
      ext_req  = ($urandom_range(0, 9) < 7);
      ext_lock = ($urandom_range(0, 9) < 6);
      rst_n    = ($urandom_range(0, 299) != 0);
      randomize_data();
      step(g, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 8: max consecutive locked external grants (range 1..31).
REQ-002 SHALL have parameter STARVE_MAX, default 16: consecutive denied external-request cycles that force an external win (range 1..31).
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  MEM-stage access request (MemRead|MemWrite).
- cpu_we  in  1  MEM-stage write.
- cpu_addr  in  32  MEM-stage ALU result address.
- cpu_wdata  in  32  MEM-stage store data.
- cpu_rdata  out  32  read data to MEM/WB latch.
- cpu_stall  out  1  freeze IF/ID/EX/MEM this cycle.
- ext_req  in  1  external (UART loader) request.
- ext_we  in  1  external write.
- ext_lock  in  1  keep grant for the next beat (burst).
- ext_addr  in  32  external address.
- ext_wdata  in  32  external write data.
- ext_gnt  out  1  external access performed this cycle.
- ext_rdata  out  32  registered external read data.
- ext_rvalid  out  1  ext_rdata valid, one cycle.
- mem_read  out  1  data-memory MemRead.
- mem_write  out  1  data-memory MemWrite.
- mem_addr  out  32  data-memory Address.
- mem_wdata  out  32  data-memory Write_data.
- mem_rdata  in  32  data-memory Read_data (combinational).

Function
REQ-004 SHALL decide the grant combinationally each cycle from requests plus registered state (last_owner, burst_cnt, starve_cnt); at most one of cpu_gnt, ext_gnt high.
REQ-005 SHALL grant cpu when only cpu_req high, ext when only ext_req high, nobody when neither.
REQ-006 SHALL, on contention, grant ext if last_owner=EXT and ext_lock was high at that grant and burst_cnt<BURST_MAX (burst continuation).
REQ-007 SHALL, on contention without burst continuation, grant ext if starve_cnt>=STARVE_MAX; otherwise apply the policy of REQ-020.
REQ-008 SHALL drive mem_addr/mem_wdata from the granted requester, mem_write=granted we, mem_read=granted & ~we; all four 0 when no grant.
REQ-009 SHALL set cpu_stall = cpu_req & ~cpu_gnt, combinationally in the same cycle.
REQ-010 SHALL drive cpu_rdata = mem_rdata when cpu_gnt & ~cpu_we, else 0.
REQ-011 SHALL register ext_rdata<=mem_rdata and ext_rvalid<=1 on the clock edge ending an ext read grant; ext_rvalid 0 otherwise, ext_rdata holds its value.
REQ-012 SHALL update last_owner on each granted cycle; unchanged on idle cycles.
REQ-013 SHALL increment burst_cnt (saturating at 31) on each consecutive ext grant with ext_lock high; reset to 0 on cpu grant, idle cycle, or ext grant with ext_lock low.
REQ-014 SHALL increment starve_cnt (saturating at 31) when ext_req high and ext_gnt low; clear to 0 on ext grant or ext_req low.
REQ-015 SHALL treat a burst reaching BURST_MAX under contention as ended: next contested cycle goes to cpu, burst_cnt cleared on that cpu grant.
REQ-016 SHALL impose no added latency: granted write commits at the same edge; granted read data same cycle (cpu) or next cycle (ext_rvalid).

Reset
REQ-017 SHALL, while rst_n low, force all grants, mem_read, mem_write, cpu_stall, ext_gnt to 0 and mem_addr, mem_wdata, cpu_rdata to 0.
REQ-018 SHALL asynchronously reset last_owner=CPU, burst_cnt=0, starve_cnt=0, ext_rvalid=0, ext_rdata=0.
REQ-019 SHALL, on reset mid-burst, drop the burst; first post-reset contested cycle resolves per REQ-020.

Configuration
REQ-020 SHALL, with MEM_ARB_RR_EN defined, resolve plain contention round-robin (requester other than last_owner wins); without it, cpu always wins plain contention (starvation guard REQ-007 still active).

Verification
REQ-021 cpu_req=1, ext_req=0, cpu_we=1, addr=0x10, wdata=0xA5 -> mem_write=1, mem_addr=0x10, cpu_stall=0 same cycle.
REQ-022 both requesting continuously, ext_lock=0, macro undefined -> cpu granted 16 cycles, ext granted on cycle 17, starve_cnt back to 0.
REQ-023 MEM_ARB_RR_EN defined, both requesting, last_owner=CPU -> grants alternate EXT,CPU,EXT,...; cpu_stall high on every EXT cycle.
REQ-024 ext burst ext_lock=1 with cpu_req=1 throughout, BURST_MAX=8 -> 8 consecutive ext grants then cpu grant, cpu_stall high exactly during burst.
REQ-025 ext read addr 0x40, mem_rdata=0x12345678 -> ext_rvalid=1, ext_rdata=0x12345678 next cycle only.
REQ-026 rst_n low during burst cycle 3 -> all outputs 0 immediately; after release with both requesting, macro undefined -> cpu granted first.
